// File: rtl/boule_rouge_ctrl_if.sv
// Red-ball layer link: spawn request/pattern/position out, move/end status back.
interface boule_rouge_ctrl_if;
  logic        e_enable_br;
  logic [5:0]  e_move_br;
  logic [20:0] e_XY0_br;
  logic        done_move_br;
  logic        br_end;

  // Controller side drives the spawn request and consumes layer status.
  modport master (
    output e_enable_br,
    output e_move_br,
    output e_XY0_br,
    input  done_move_br,
    input  br_end
  );

  // Ball layer side.
  modport slave (
    input  e_enable_br,
    input  e_move_br,
    input  e_XY0_br,
    output done_move_br,
    output br_end
  );
endinterface

// File: rtl/boule_rouge_ctrl.sv
// Red ball spawn and tracking controller: schedules spawns, picks start cube and
// move pattern from an LFSR, follows the ball cube by cube on the pyramid.
module boule_rouge_ctrl #(
  parameter logic [31:0] SPAWN_DELAY = 32'd50_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  e_start_qb,
  input  logic                  e_pause_qb,
  input  logic                  e_resume_qb,
  input  logic                  freeze_power,
  input  logic [20:0]           e_XY_c2,
  input  logic [20:0]           e_XY_c3,
  boule_rouge_ctrl_if.master    br,
  output logic [4:0]            br_cube,
  output logic [2:0]            br_row,
  output logic                  br_active,
  output logic [7:0]            spawn_cnt
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned MOVE_W = 6;
  localparam int unsigned XY_W   = 21;
  localparam int unsigned CUBE_W = 5;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SCNT_W = 8;

  // An all-zero seed would lock the LFSR, so fall back to the default seed.
  localparam logic [LFSR_W-1:0] SEED     = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [CNT_W-1:0]  DLY_LAST = SPAWN_DELAY - 32'd1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(MOVE_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SPAWN,
    S_TRACK,
    S_DRAIN,
    S_PAUSE
  } state_t;

  state_t state, state_nxt;
  state_t saved, saved_nxt;

  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [CNT_W-1:0]  dly_cnt, dly_cnt_nxt;
  logic              enable_q, enable_nxt;
  logic [MOVE_W-1:0] move_q, move_nxt;
  logic [XY_W-1:0]   xy0_q, xy0_nxt;
  logic [CUBE_W-1:0] cube_q, cube_nxt;
  logic [ROW_W-1:0]  row_q, row_nxt;
  logic              active_q, active_nxt;
  logic [SCNT_W-1:0] scnt_q, scnt_nxt;
  logic [CUBE_W-1:0] start_cube, start_cube_nxt;
  logic [IDX_W-1:0]  move_idx, move_idx_nxt;

  logic done_q1, done_q2, end_q1, end_q2;
  logic done_rise, end_rise;
  logic lfsr_fb;
  logic move_bit;
  logic [CUBE_W-1:0] cube_step;

  assign br.e_enable_br = enable_q;
  assign br.e_move_br   = move_q;
  assign br.e_XY0_br    = xy0_q;
  assign br_cube        = cube_q;
  assign br_row         = row_q;
  assign br_active      = active_q;
  assign spawn_cnt      = scnt_q;

  assign done_rise = done_q1 & ~done_q2;
  assign end_rise  = end_q1 & ~end_q2;
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign move_bit  = move_q[move_idx];
  assign cube_step = cube_q + CUBE_W'(row_q) + CUBE_W'(move_bit);

  // Layer status sampling; the delayed copy turns levels into rise events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q1 <= 1'b0;
      done_q2 <= 1'b0;
      end_q1  <= 1'b0;
      end_q2  <= 1'b0;
    end else begin
      done_q1 <= br.done_move_br;
      done_q2 <= done_q1;
      end_q1  <= br.br_end;
      end_q2  <= end_q1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      saved <= S_IDLE;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
    end
  end

  // Next state and next register values; priority start > pause > end > done.
  always_comb begin
    state_nxt      = state;
    saved_nxt      = saved;
    lfsr_nxt       = (state == S_PAUSE) ? lfsr : {lfsr[LFSR_W-2:0], lfsr_fb};
    dly_cnt_nxt    = dly_cnt;
    enable_nxt     = enable_q;
    move_nxt       = move_q;
    xy0_nxt        = xy0_q;
    cube_nxt       = cube_q;
    row_nxt        = row_q;
    active_nxt     = active_q;
    scnt_nxt       = scnt_q;
    start_cube_nxt = start_cube;
    move_idx_nxt   = move_idx;

    if (e_start_qb) begin
      state_nxt    = S_WAIT;
      dly_cnt_nxt  = '0;
      scnt_nxt     = '0;
      cube_nxt     = '0;
      row_nxt      = '0;
      active_nxt   = 1'b0;
      enable_nxt   = 1'b0;
      move_idx_nxt = '0;
    end else if (e_pause_qb && (state != S_IDLE) && (state != S_PAUSE)) begin
      saved_nxt = state;
      state_nxt = S_PAUSE;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_WAIT: begin
          if (!freeze_power) begin
            if (dly_cnt == DLY_LAST) begin
              dly_cnt_nxt    = '0;
              move_nxt       = lfsr[MOVE_W-1:0];
              xy0_nxt        = lfsr[6] ? e_XY_c3 : e_XY_c2;
              start_cube_nxt = lfsr[6] ? 5'd3 : 5'd2;
              enable_nxt     = 1'b1;
              active_nxt     = 1'b1;
              scnt_nxt       = scnt_q + 8'd1;
              state_nxt      = S_SPAWN;
            end else begin
              dly_cnt_nxt = dly_cnt + 32'd1;
            end
          end
        end

        S_SPAWN, S_TRACK, S_DRAIN: begin
          if (end_rise) begin
            // Any end (normal, KO, screen clear) restarts the spawn delay.
            active_nxt   = 1'b0;
            cube_nxt     = '0;
            row_nxt      = '0;
            enable_nxt   = 1'b0;
            dly_cnt_nxt  = '0;
            move_idx_nxt = '0;
            state_nxt    = S_WAIT;
          end else if (done_rise) begin
            if (state == S_SPAWN) begin
              enable_nxt   = 1'b0;
              cube_nxt     = start_cube;
              row_nxt      = 3'd2;
              move_idx_nxt = '0;
              state_nxt    = S_TRACK;
            end else if (state == S_TRACK) begin
              if (row_q == ROW_LAST) begin
                cube_nxt = '0;
                row_nxt  = '0;
              end else begin
                cube_nxt = cube_step;
                row_nxt  = row_q + 3'd1;
              end
              move_idx_nxt = move_idx + 3'd1;
              if (move_idx == IDX_LAST) begin
                state_nxt = S_DRAIN;
              end
            end
          end
        end

        S_PAUSE: begin
          if (e_resume_qb) begin
            state_nxt = saved;
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr       <= SEED;
      dly_cnt    <= '0;
      enable_q   <= 1'b0;
      move_q     <= '0;
      xy0_q      <= '0;
      cube_q     <= '0;
      row_q      <= '0;
      active_q   <= 1'b0;
      scnt_q     <= '0;
      start_cube <= '0;
      move_idx   <= '0;
    end else begin
      lfsr       <= lfsr_nxt;
      dly_cnt    <= dly_cnt_nxt;
      enable_q   <= enable_nxt;
      move_q     <= move_nxt;
      xy0_q      <= xy0_nxt;
      cube_q     <= cube_nxt;
      row_q      <= row_nxt;
      active_q   <= active_nxt;
      scnt_q     <= scnt_nxt;
      start_cube <= start_cube_nxt;
      move_idx   <= move_idx_nxt;
    end
  end

endmodule
